// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter
// Shares one single-port memory bus between the IFU instruction port and the
// LSU data port. At most one transaction is outstanding: the winner's command
// is registered onto mem_*, the owner is remembered, and the memory response
// is steered back to that owner in the same cycle it arrives. A hung bus is
// turned into a bus error after TIMEOUT_CYCLES cycles in REQ+RESP.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   instr_*              IFU read port (req/addr in, rvalid/rdata/err out)
//   data_*               LSU port (req/addr/we/wdata in, rvalid/wvalid/rdata/err out)
//   mem_*                memory side (req/addr/we/wdata out, gnt/rvalid/rdata/err in)
//
// State | meaning
// IDLE  | no transaction; arbitrate and latch the winner's command
// REQ   | mem_req_o high, waiting for mem_gnt_i
// RESP  | request accepted, waiting for mem_rvalid_i

module jedro_1_mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  instr_req_i,
    input  logic [DATA_WIDTH-1:0] instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  data_req_i,
    input  logic [DATA_WIDTH-1:0] data_addr_i,
    input  logic [3:0]            data_we_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic                  data_wvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);

    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                state_q, state_d;
    logic                  owner_data_q, owner_data_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic resp_fire;
    logic timeout;
    logic instr_win;
    logic owner_err;

    assign resp_fire = (state_q == RESP) && mem_rvalid_i;
    assign timeout   = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1)) && !resp_fire;
    // Instr only overrides data once the data side has used up its streak.
    assign instr_win = instr_req_i && (!data_req_i || (streak_q == SW'(DATA_STREAK_MAX)));
    assign owner_err = (resp_fire && mem_err_i) || timeout;

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        mem_req_d    = mem_req_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        streak_d     = streak_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE: begin
                if (instr_req_i || data_req_i) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    timer_d   = '0;
                    if (instr_win) begin
                        owner_data_d = 1'b0;
                        addr_d       = instr_addr_i;
                        we_d         = 4'h0;
                        wdata_d      = '0;
                        streak_d     = '0;
                    end else begin
                        owner_data_d = 1'b1;
                        addr_d       = data_addr_i;
                        we_d         = data_we_i;
                        wdata_d      = data_wdata_i;
                        // Data can only win with instr pending while streak < max,
                        // so the increment never passes the saturation value.
                        streak_d     = instr_req_i ? streak_q + SW'(1) : '0;
                    end
                end
            end
            REQ: begin
                timer_d = timer_q + TW'(1);
                if (timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (mem_gnt_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                end
            end
            RESP: begin
                timer_d = timer_q + TW'(1);
                if (resp_fire || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            we_q         <= 4'h0;
            wdata_q      <= '0;
            streak_q     <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            mem_req_q    <= mem_req_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            streak_q     <= streak_d;
            timer_q      <= timer_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;

    // Response steering is combinational so the owner sees it with zero added latency.
    assign instr_rvalid_o = resp_fire && !owner_data_q && !mem_err_i;
    assign instr_err_o    = !owner_data_q && owner_err;
    assign instr_rdata_o  = (resp_fire && !owner_data_q) ? mem_rdata_i : '0;
    assign data_rvalid_o  = resp_fire && owner_data_q && (we_q == 4'h0) && !mem_err_i;
    assign data_wvalid_o  = resp_fire && owner_data_q && (we_q != 4'h0) && !mem_err_i;
    assign data_err_o     = owner_data_q && owner_err;
    assign data_rdata_o   = (resp_fire && owner_data_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
module tb_jedro_1_mem_arbiter;

    localparam int MAX = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic        data_wvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .DATA_STREAK_MAX(MAX), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o), .data_wvalid_o(data_wvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int tests  = 0;
    int failed = 0;

    // Reference model: pending requests of each master and the data streak.
    bit          ip, dp;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe;
    int          streak_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        instr_req_i  = ip;
        instr_addr_i = ia;
        data_req_i   = dp;
        data_addr_i  = da;
        data_we_i    = dwe;
        data_wdata_i = dwd;
    endtask

    function automatic logic [4:0] pulses();
        return {instr_rvalid_o, instr_err_o, data_rvalid_o, data_wvalid_o, data_err_o};
    endfunction

    // Entered at the negedge of an IDLE cycle with requests driven; returns at
    // the negedge of the IDLE cycle that follows the response or timeout.
    // g: wait cycles before gnt, r: cycles after gnt before rvalid.
    task automatic access(input int g, input int r, input bit e, input logic [31:0] rd);
        bit         iw;
        bit         done;
        int         kr;
        logic [4:0] exp_p;
        iw = ip && (!dp || streak_m == MAX);
        if (iw)      streak_m = 0;
        else if (ip) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
        else         streak_m = 0;
        kr = g + r + 2;  // index of the response cycle within REQ+RESP
        @(posedge clk_i); @(negedge clk_i);
        check("mem_addr",  mem_addr_o,  iw ? ia : da);
        check("mem_we",    mem_we_o,    iw ? 4'h0 : dwe);
        check("mem_wdata", mem_wdata_o, iw ? 32'h0 : dwd);
        for (int k = 1; k <= 64; k++) begin
            if (k > 1) begin @(posedge clk_i); @(negedge clk_i); end
            check("mem_req", mem_req_o, 64'(k <= g + 1));
            mem_gnt_i = (k == g + 1);
            if (k == kr) begin
                mem_rvalid_i = 1'b1; mem_err_i = e; mem_rdata_i = rd;
            end else if (k <= g + 1) begin
                // rvalid while still requesting must be ignored
                mem_rvalid_i = 1'($urandom_range(0, 1)); mem_err_i = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
            end else begin
                mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
            end
            #1;
            done  = 1'b0;
            exp_p = 5'b0;
            if (k == kr) begin
                done  = 1'b1;
                exp_p = iw ? {~e, e, 3'b000}
                           : {2'b00, (dwe == 4'h0) && !e, (dwe != 4'h0) && !e, e};
            end else if (k == 64) begin
                done  = 1'b1;
                exp_p = iw ? 5'b01000 : 5'b00001;
            end
            check("pulses", pulses(), exp_p);
            if (k == kr) begin
                check("instr_rdata", instr_rdata_o, iw ? rd : 32'h0);
                check("data_rdata",  data_rdata_o,  iw ? 32'h0 : rd);
            end
            if (done) break;
        end
        if (iw) ip = 1'b0; else dp = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        drive_reqs();
        check("turnaround_idle", mem_req_o, 0);
    endtask

    initial begin
        int g, r;
        bit e;
        ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dwe = 0; streak_m = 0;
        rstn_i = 1'b0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
        drive_reqs();
        @(negedge clk_i); @(negedge clk_i);
        check("rst_mem_req",   mem_req_o,  0);
        check("rst_mem_addr",  mem_addr_o, 0);
        check("rst_mem_we",    mem_we_o,   0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_pulses",    pulses(),   0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Instruction fetch only, best-case timing
        ip = 1; ia = 32'h100; drive_reqs();
        access(0, 0, 0, 32'h0050_0093);

        // Simultaneous requests: data store wins, instr follows next IDLE
        ip = 1; ia = 32'h300;
        dp = 1; da = 32'h2000; dwe = 4'hF; dwd = 32'hCAFE_F00D; drive_reqs();
        access(0, 0, 0, 32'h0);
        access(1, 1, 0, 32'h1234_5678);

        // Starvation: both held; 4 data grants then 1 instr grant, repeating
        for (int n = 0; n < 10; n++) begin
            if (!ip) begin ip = 1; ia = 32'h1000 + 32'(n * 4); end
            if (!dp) begin dp = 1; da = 32'h8000 + 32'(n * 4); dwe = 4'h0; dwd = 32'(n); end
            drive_reqs();
            access(0, 0, 0, $urandom);
        end
        ip = 0; drive_reqs();
        // drain the remaining data request
        if (dp) access(0, 0, 0, $urandom);

        // Data load with bus error
        dp = 1; da = 32'h4004; dwe = 4'h0; drive_reqs();
        access(0, 1, 1, 32'hDEAD_BEEF);

        // Timeout after gnt, then a late rvalid at cycle 70 is discarded
        dp = 1; da = 32'h4008; dwe = 4'h3; dwd = 32'h55; drive_reqs();
        access(0, 200, 0, 32'h0);
        for (int k = 66; k <= 70; k++) begin @(posedge clk_i); @(negedge clk_i); end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; #1;
        check("late_rvalid_pulses", pulses(), 0);
        check("late_rvalid_irdata", instr_rdata_o, 0);
        check("late_rvalid_mreq",   mem_req_o, 0);
        @(posedge clk_i); @(negedge clk_i);
        mem_rvalid_i = 1'b0;

        // Asynchronous reset while a response is on the bus
        dp = 1; da = 32'h6000; dwe = 4'h0; drive_reqs();
        @(posedge clk_i); @(negedge clk_i);
        check("rstmid_mreq_req", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b0; mem_rdata_i = 32'h77; #1;
        check("rstmid_before", pulses(), 5'b00100);
        #1 rstn_i = 1'b0; #1;
        check("rstmid_pulses", pulses(), 0);
        check("rstmid_mreq",   mem_req_o, 0);
        check("rstmid_drdata", data_rdata_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1; mem_rvalid_i = 1'b0; streak_m = 0;
        access(0, 0, 0, 32'h88);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom & 32'hFFFC; end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; da = $urandom; dwd = $urandom;
                dwe = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (!ip && !dp) begin
                @(posedge clk_i); @(negedge clk_i);
                check("idle_mreq", mem_req_o, 0);
                check("idle_pulses", pulses(), 0);
                ip = 1; ia = $urandom & 32'hFFFC;
            end
            drive_reqs();
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) r = 80;
            e = ($urandom_range(0, 7) == 0);
            access(g, r, e, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
